// File: rtl/seq_stage_ctrl_if.sv
// Handshake and status bundle between the Y86-64 sequencer and the fetch/memory stages.
// The slave modport is the sequencer's view; the master modport is the surrounding datapath.
interface seq_stage_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             start_i;
   logic             instr_valid_i;
   logic             imem_error_i;
   logic [3:0]       icode_i;
   logic             dmem_ready_i;
   logic             dmem_error_i;
   logic             fetch_en_o;
   logic             decode_en_o;
   logic             execute_en_o;
   logic             mem_en_o;
   logic             wb_en_o;
   logic             pc_en_o;
   logic [2:0]       stat_o;
   logic             halted_o;
   logic [3:0]       state_o;
   logic [CNT_W-1:0] instr_cnt_o;

   modport slave (
      input  start_i, instr_valid_i, imem_error_i, icode_i, dmem_ready_i, dmem_error_i,
      output fetch_en_o, decode_en_o, execute_en_o, mem_en_o, wb_en_o, pc_en_o,
      output stat_o, halted_o, state_o, instr_cnt_o
   );

   modport master (
      output start_i, instr_valid_i, imem_error_i, icode_i, dmem_ready_i, dmem_error_i,
      input  fetch_en_o, decode_en_o, execute_en_o, mem_en_o, wb_en_o, pc_en_o,
      input  stat_o, halted_o, state_o, instr_cnt_o
   );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle Moore sequencer for the sequential Y86-64 core: walks each instruction through
// its stages, waits on memory handshakes with a timeout and reports AOK/HLT/ADR/INS status.
module seq_stage_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   seq_stage_ctrl_if.slave ctrl_if
);

   typedef enum logic [3:0] {
      StIdle      = 4'd0,
      StFetch     = 4'd1,
      StDecode    = 4'd2,
      StExecute   = 4'd3,
      StMemory    = 4'd4,
      StWriteback = 4'd5,
      StPcUpd     = 4'd6,
      StHalt      = 4'd7,
      StErr       = 4'd8
   } state_e;

   localparam logic [2:0] StatAok = 3'd1;
   localparam logic [2:0] StatHlt = 3'd2;
   localparam logic [2:0] StatAdr = 3'd3;
   localparam logic [2:0] StatIns = 3'd4;

   state_e           state_q, state_d;
   logic [2:0]       stat_q, stat_d;
   logic [7:0]       wait_q, wait_d;
   logic [3:0]       icode_q, icode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [8:0]       wait_inc;
   logic             wait_expired;
   logic             is_mem_op;
   logic             is_wb_op;

   assign wait_inc     = {1'b0, wait_q} + 9'd1;
   assign wait_expired = (wait_inc == 9'(MEM_TIMEOUT));

   // Classification uses the icode latched in FETCH, not the live bus value.
   always_comb begin
      is_mem_op = 1'b0;
      is_wb_op  = 1'b0;
      unique case (icode_q)
         4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_op = 1'b1;
         4'h2, 4'h3, 4'h6:                   is_wb_op  = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      icode_d = icode_q;
      cnt_d   = cnt_q;
      // Any transition clears the wait counter; only a waiting cycle overrides this.
      wait_d  = '0;
      unique case (state_q)
         StIdle: begin
            if (ctrl_if.start_i) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (ctrl_if.imem_error_i) begin
               state_d = StErr;
               stat_d  = StatAdr;
            end else if (ctrl_if.instr_valid_i) begin
               icode_d = ctrl_if.icode_i;
               if (ctrl_if.icode_i == 4'h0) begin
                  state_d = StHalt;
                  stat_d  = StatHlt;
               end else if (ctrl_if.icode_i > 4'hB) begin
                  state_d = StErr;
                  stat_d  = StatIns;
               end else begin
                  state_d = StDecode;
               end
            end else if (wait_expired) begin
               state_d = StErr;
               stat_d  = StatAdr;
            end else begin
               wait_d = wait_inc[7:0];
            end
         end
         StDecode: begin
            state_d = StExecute;
         end
         StExecute: begin
            if (is_mem_op) begin
               state_d = StMemory;
            end else if (is_wb_op) begin
               state_d = StWriteback;
            end else begin
               state_d = StPcUpd;
            end
         end
         StMemory: begin
            if (ctrl_if.dmem_error_i) begin
               state_d = StErr;
               stat_d  = StatAdr;
            end else if (ctrl_if.dmem_ready_i) begin
               // RMMOVQ stores only; every other memory op has a register to write.
               state_d = (icode_q == 4'h4) ? StPcUpd : StWriteback;
            end else if (wait_expired) begin
               state_d = StErr;
               stat_d  = StatAdr;
            end else begin
               wait_d = wait_inc[7:0];
            end
         end
         StWriteback: begin
            state_d = StPcUpd;
         end
         StPcUpd: begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = StFetch;
         end
         StHalt, StErr: ;
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         stat_q  <= StatAok;
         wait_q  <= '0;
         icode_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
         wait_q  <= wait_d;
         icode_q <= icode_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ctrl_if.fetch_en_o   = (state_q == StFetch);
   assign ctrl_if.decode_en_o  = (state_q == StDecode);
   assign ctrl_if.execute_en_o = (state_q == StExecute);
   assign ctrl_if.mem_en_o     = (state_q == StMemory);
   assign ctrl_if.wb_en_o      = (state_q == StWriteback);
   assign ctrl_if.pc_en_o      = (state_q == StPcUpd);
   assign ctrl_if.halted_o     = (state_q == StHalt) || (state_q == StErr);
   assign ctrl_if.stat_o       = stat_q;
   assign ctrl_if.state_o      = state_q;
   assign ctrl_if.instr_cnt_o  = cnt_q;

   a_enables_onehot0: assert property (@(posedge clk_i)
      $onehot0({ctrl_if.fetch_en_o, ctrl_if.decode_en_o, ctrl_if.execute_en_o,
                ctrl_if.mem_en_o, ctrl_if.wb_en_o, ctrl_if.pc_en_o}));

   a_halt_absorbing: assert property (@(posedge clk_i) disable iff (rst_i)
      ((state_q == StHalt) || (state_q == StErr)) |=> ($stable(state_q) && $stable(stat_q)));

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed scenarios plus randomized instruction
// streams compared cycle by cycle against a stage-list model of each instruction.
module tb_seq_stage_ctrl;

   localparam logic [3:0] SIdle = 4'd0, SFetch = 4'd1, SDecode = 4'd2, SExecute = 4'd3;
   localparam logic [3:0] SMemory = 4'd4, SWb = 4'd5, SPc = 4'd6, SHalt = 4'd7, SErr = 4'd8;
   localparam int unsigned Tmo = 15;

   typedef struct {
      logic [3:0]  st;
      logic [2:0]  stat;
      logic [31:0] cnt;
      logic        start, valid, ierr, dready, derr;
      logic [3:0]  icode;
   } cyc_t;

   logic clk = 1'b0;
   logic rst, rst2;
   int   total, bad;
   cyc_t tr[$];
   logic [31:0] m_cnt;
   logic [2:0]  m_stat;

   always #5 clk = ~clk;

   seq_stage_ctrl_if #(.CNT_W(32)) bus ();
   seq_stage_ctrl_if #(.CNT_W(2))  bus2 ();

   seq_stage_ctrl #(.MEM_TIMEOUT(Tmo), .CNT_W(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .ctrl_if (bus)
   );

   seq_stage_ctrl #(.MEM_TIMEOUT(Tmo), .CNT_W(2)) dut2 (
      .clk_i   (clk),
      .rst_i   (rst2),
      .ctrl_if (bus2)
   );

   function automatic logic rb();
      return 1'($urandom_range(1, 0));
   endfunction

   function automatic logic [3:0] rn();
      return 4'($urandom_range(15, 0));
   endfunction

   // Expected output vector: each enable is high exactly while in its own stage.
   function automatic logic [13:0] exp_vec(input logic [3:0] st, input logic [2:0] s);
      return {st, st == SFetch, st == SDecode, st == SExecute, st == SMemory, st == SWb,
              st == SPc, s, (st == SHalt) || (st == SErr)};
   endfunction

   function automatic logic [13:0] obs();
      return {bus.state_o, bus.fetch_en_o, bus.decode_en_o, bus.execute_en_o, bus.mem_en_o,
              bus.wb_en_o, bus.pc_en_o, bus.stat_o, bus.halted_o};
   endfunction

   function automatic void push(input logic [3:0] st, input logic s, input logic v,
                                input logic ie, input logic [3:0] ic, input logic dr,
                                input logic de);
      cyc_t c;
      c.st = st; c.stat = m_stat; c.cnt = m_cnt;
      c.start = s; c.valid = v; c.ierr = ie; c.icode = ic; c.dready = dr; c.derr = de;
      tr.push_back(c);
   endfunction

   function automatic bit enter(input logic [3:0] st, input logic [2:0] s);
      m_stat = s;
      for (int k = 0; k < 3; k++) push(st, rb(), rb(), rb(), rn(), rb(), rb());
      return 1'b1;
   endfunction

   // Appends the expected cycles of one instruction; returns 1 if the core stops.
   function automatic bit model_instr(input logic [3:0] ic, input int fw, input int mw,
                                      input bit ierr, input bit derr);
      bit mem_op = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      for (int k = 0; k <= fw; k++) begin
         if (k == fw) begin
            if (ierr) begin
               push(SFetch, rb(), 1'b1, 1'b1, rn(), rb(), rb());
               return enter(SErr, 3'd3);
            end
            push(SFetch, rb(), 1'b1, 1'b0, ic, rb(), rb());
         end else begin
            push(SFetch, rb(), 1'b0, 1'b0, rn(), rb(), rb());
            if (k + 1 == int'(Tmo)) return enter(SErr, 3'd3);
         end
      end
      if (ic == 4'h0) return enter(SHalt, 3'd2);
      if (ic > 4'hB) return enter(SErr, 3'd4);
      push(SDecode, rb(), rb(), rb(), rn(), rb(), rb());
      push(SExecute, rb(), rb(), rb(), rn(), rb(), rb());
      if (mem_op) begin
         for (int k = 0; k <= mw; k++) begin
            if (k == mw) begin
               if (derr) begin
                  push(SMemory, rb(), rb(), rb(), rn(), rb(), 1'b1);
                  return enter(SErr, 3'd3);
               end
               push(SMemory, rb(), rb(), rb(), rn(), 1'b1, 1'b0);
            end else begin
               push(SMemory, rb(), rb(), rb(), rn(), 1'b0, 1'b0);
               if (k + 1 == int'(Tmo)) return enter(SErr, 3'd3);
            end
         end
      end
      if (ic != 4'h4 && (mem_op || ic inside {4'h2, 4'h3, 4'h6})) begin
         push(SWb, rb(), rb(), rb(), rn(), rb(), rb());
      end
      push(SPc, rb(), rb(), rb(), rn(), rb(), rb());
      m_cnt = m_cnt + 32'd1;
      return 1'b0;
   endfunction

   task automatic drive(input logic s, input logic v, input logic ie, input logic [3:0] ic,
                        input logic dr, input logic de);
      bus.start_i = s; bus.instr_valid_i = v; bus.imem_error_i = ie;
      bus.icode_i = ic; bus.dmem_ready_i = dr; bus.dmem_error_i = de;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (obs() !== exp_vec(SIdle, 3'd1)) begin
         bad++; $display("FAIL reset_outputs got=%h exp=%h", obs(), exp_vec(SIdle, 3'd1));
      end
      total++;
      if (bus.instr_cnt_o !== 32'd0) begin
         bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.instr_cnt_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_nop_timing();
      logic [3:0] exp_st;
      do_reset();
      drive(1, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      drive(0, 1, 0, 4'h1, 0, 0);
      for (int c = 0; c < 5; c++) begin
         exp_st = (c == 0 || c == 4) ? SFetch : (c == 1) ? SDecode : (c == 2) ? SExecute : SPc;
         total++;
         if (obs() !== exp_vec(exp_st, 3'd1)) begin
            bad++; $display("FAIL nop_cycle%0d got=%h exp=%h", c, obs(), exp_vec(exp_st, 3'd1));
         end
         if (c == 4) begin
            total++;
            if (bus.instr_cnt_o !== 32'd1) begin
               bad++; $display("FAIL nop_cnt got=%0d exp=1", bus.instr_cnt_o);
            end
         end
         @(negedge clk);
      end
      drive(0, 0, 0, 4'h0, 0, 0);
   endtask

   task automatic test_mem_timeout();
      int mem_cyc = 0, pc_seen = 0;
      do_reset();
      drive(1, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      drive(0, 1, 0, 4'h9, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      repeat (2) @(negedge clk);
      for (int c = 0; c < 20; c++) begin
         if (bus.mem_en_o === 1'b1) mem_cyc++;
         if (bus.pc_en_o === 1'b1) pc_seen++;
         @(negedge clk);
      end
      total++;
      if (mem_cyc != int'(Tmo)) begin
         bad++; $display("FAIL timeout_mem_cycles got=%0d exp=%0d", mem_cyc, Tmo);
      end
      total++;
      if (pc_seen != 0) begin
         bad++; $display("FAIL timeout_pc_pulses got=%0d exp=0", pc_seen);
      end
      total++;
      if (obs() !== exp_vec(SErr, 3'd3)) begin
         bad++; $display("FAIL timeout_err got=%h exp=%h", obs(), exp_vec(SErr, 3'd3));
      end
   endtask

   task automatic test_halt_and_illegal();
      do_reset();
      drive(1, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      drive(0, 1, 0, 4'h0, 0, 0);
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         drive(1, 1, 0, 4'h1, 1, 0);
         total++;
         if (obs() !== exp_vec(SHalt, 3'd2)) begin
            bad++; $display("FAIL halt_cycle%0d got=%h exp=%h", c, obs(), exp_vec(SHalt, 3'd2));
         end
         @(negedge clk);
      end
      do_reset();
      drive(1, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      drive(0, 1, 0, 4'hC, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      total++;
      if (obs() !== exp_vec(SErr, 3'd4)) begin
         bad++; $display("FAIL illegal_icode got=%h exp=%h", obs(), exp_vec(SErr, 3'd4));
      end
   endtask

   task automatic test_fault_priority();
      do_reset();
      drive(1, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      drive(0, 1, 1, 4'h2, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      total++;
      if (obs() !== exp_vec(SErr, 3'd3)) begin
         bad++; $display("FAIL imem_priority got=%h exp=%h", obs(), exp_vec(SErr, 3'd3));
      end
      do_reset();
      drive(1, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      drive(0, 1, 0, 4'h5, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      repeat (2) @(negedge clk);
      drive(0, 0, 0, 4'h0, 1, 1);
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      total++;
      if (obs() !== exp_vec(SErr, 3'd3)) begin
         bad++; $display("FAIL dmem_priority got=%h exp=%h", obs(), exp_vec(SErr, 3'd3));
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      drive(0, 1, 0, 4'h1, 0, 0);
      repeat (4) @(negedge clk);
      drive(0, 1, 0, 4'h5, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      repeat (3) @(negedge clk);
      total++;
      if ({bus.state_o, bus.instr_cnt_o} !== {SMemory, 32'd1}) begin
         bad++; $display("FAIL mid_mem_pre got=%h/%0d exp=%h/1", bus.state_o, bus.instr_cnt_o,
                         SMemory);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({obs(), bus.instr_cnt_o} !== {exp_vec(SIdle, 3'd1), 32'd0}) begin
         bad++; $display("FAIL mid_mem_reset got=%h exp=%h", {obs(), bus.instr_cnt_o},
                         {exp_vec(SIdle, 3'd1), 32'd0});
      end
      drive(1, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      drive(0, 1, 0, 4'h0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({obs(), bus.instr_cnt_o} !== {exp_vec(SIdle, 3'd1), 32'd0}) begin
         bad++; $display("FAIL halt_reset got=%h exp=%h", {obs(), bus.instr_cnt_o},
                         {exp_vec(SIdle, 3'd1), 32'd0});
      end
   endtask

   task automatic test_cnt_wrap();
      logic [1:0] exp2;
      rst2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      bus2.start_i = 1'b1;
      @(negedge clk);
      bus2.start_i = 1'b0; bus2.instr_valid_i = 1'b1; bus2.icode_i = 4'h1;
      for (int c = 0; c <= 20; c++) begin
         if (c > 0 && c % 4 == 0) begin
            exp2 = 2'((c / 4) % 4);
            total++;
            if (bus2.instr_cnt_o !== exp2) begin
               bad++; $display("FAIL cnt_wrap_%0d got=%0d exp=%0d", c / 4, bus2.instr_cnt_o, exp2);
            end
         end
         @(negedge clk);
      end
      bus2.instr_valid_i = 1'b0;
   endtask

   task automatic test_random_stream();
      logic [3:0] mem_ops [6] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      bit done;
      int n;
      for (int ep = 0; ep < 25; ep++) begin
         tr.delete();
         m_cnt = '0;
         m_stat = 3'd1;
         done = 1'b0;
         repeat ($urandom_range(2, 0)) push(SIdle, 1'b0, rb(), rb(), rn(), rb(), rb());
         push(SIdle, 1'b1, rb(), rb(), rn(), rb(), rb());
         if (ep == 0) begin
            void'(model_instr(4'h6, 0, 0, 0, 0));
            void'(model_instr(4'h5, 0, 0, 0, 0));
            void'(model_instr(4'h4, 0, 0, 0, 0));
            void'(model_instr(4'h9, 0, 3, 0, 0));
         end
         n = $urandom_range(8, 2);
         for (int k = 0; k < n && !done; k++) begin
            done = model_instr(4'($urandom_range(11, 1)), $urandom_range(3, 0),
                               $urandom_range(4, 0), 0, 0);
         end
         if (!done) begin
            case ($urandom_range(4, 0))
               0: void'(model_instr(4'h0, $urandom_range(3, 0), 0, 0, 0));
               1: void'(model_instr(4'($urandom_range(15, 12)), $urandom_range(3, 0), 0, 0, 0));
               2: void'(model_instr(4'h1, $urandom_range(3, 0), 0, 1, 0));
               3: void'(model_instr(mem_ops[$urandom_range(5, 0)], 0, $urandom_range(3, 0), 0, 1));
               default: begin
                  if (rb()) void'(model_instr(4'h1, Tmo + 2, 0, 0, 0));
                  else void'(model_instr(4'h8, 0, Tmo + 5, 0, 0));
               end
            endcase
         end
         do_reset();
         for (int i = 0; i < tr.size(); i++) begin
            total++;
            if (obs() !== exp_vec(tr[i].st, tr[i].stat)) begin
               bad++; $display("FAIL rand_ep%0d_cyc%0d outputs got=%h exp=%h", ep, i, obs(),
                               exp_vec(tr[i].st, tr[i].stat));
            end
            total++;
            if (bus.instr_cnt_o !== tr[i].cnt) begin
               bad++; $display("FAIL rand_ep%0d_cyc%0d cnt got=%0d exp=%0d", ep, i,
                               bus.instr_cnt_o, tr[i].cnt);
            end
            drive(tr[i].start, tr[i].valid, tr[i].ierr, tr[i].icode, tr[i].dready, tr[i].derr);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      rst2 = 1'b1;
      drive(0, 0, 0, 4'h0, 0, 0);
      bus2.start_i = 1'b0; bus2.instr_valid_i = 1'b0; bus2.imem_error_i = 1'b0;
      bus2.icode_i = 4'h0; bus2.dmem_ready_i = 1'b0; bus2.dmem_error_i = 1'b0;
      test_reset();
      test_nop_timing();
      test_mem_timeout();
      test_halt_and_illegal();
      test_fault_priority();
      test_reset_mid();
      test_cnt_wrap();
      test_random_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
- Multi-cycle sequencer for the sequential Y86-64 core.
- Steps each instruction through fetch, decode, execute, memory, writeback and PC-update by issuing one-hot stage enables; pc_en_o is the strobe on which the PC-update stage commits the next PC.
- Skips memory/writeback for instructions that do not need them, waits on instruction/data memory handshakes with a timeout, and raises Y86 status codes (AOK/HLT/ADR/INS) on halt or fault.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles in FETCH or MEMORY before ADR fault (1..255).
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  leave IDLE and begin fetching
- instr_valid_i  in  1  fetch data valid (icode_i sampled this cycle)
- imem_error_i  in  1  instruction fetch address fault
- icode_i  in  4  fetched icode
- dmem_ready_i  in  1  data memory access complete
- dmem_error_i  in  1  data memory address fault
- fetch_en_o  out  1  fetch stage enable
- decode_en_o  out  1  decode stage enable
- execute_en_o  out  1  execute stage enable
- mem_en_o  out  1  data memory request, held until ready
- wb_en_o  out  1  register-file writeback enable
- pc_en_o  out  1  PC-update commit strobe
- stat_o  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- halted_o  out  1  core stopped (HLT/ADR/INS)
- state_o  out  4  current state encoding (debug)
- instr_cnt_o  out  CNT_W  retired instruction count

Behaviour:
- Moore FSM; all enables decoded from the state register, so each is high exactly while in its state.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PC_UPD=6, HALT=7, ERR=8.
- Reset (rst_i high at a clock edge, from any state):
  - state IDLE, all enables 0, stat_o=1, halted_o=0, instr_cnt_o=0, wait counter 0, latched icode 0.
- IDLE: start_i=1 -> FETCH; otherwise stay.
- FETCH: fetch_en_o=1 each cycle. Priority order:
  - imem_error_i=1 -> ERR, stat=ADR.
  - instr_valid_i=1: latch icode_i.
    - icode 0 -> HALT, stat=HLT.
    - icode >0xB -> ERR, stat=INS.
    - else -> DECODE.
  - neither: wait counter increments; counter reaching MEM_TIMEOUT -> ERR, stat=ADR.
- DECODE -> EXECUTE, one cycle.
- EXECUTE, one cycle:
  - memory icodes 4,5,8,9,A,B -> MEMORY.
  - else writeback icodes 2,3,6 -> WRITEBACK.
  - else (1, 7) -> PC_UPD.
- MEMORY: mem_en_o=1 each cycle. Priority order:
  - dmem_error_i -> ERR, stat=ADR (also when dmem_ready_i is high in the same cycle).
  - dmem_ready_i -> WRITEBACK for icodes 5,8,9,A,B; PC_UPD for icode 4.
  - neither: wait counter increments; counter reaching MEM_TIMEOUT -> ERR, stat=ADR.
- Wait counter clears on every state entry.
- WRITEBACK -> PC_UPD, one cycle. Conditional moves still pass through; the writeback stage gates on cnd.
- PC_UPD: pc_en_o=1 for one cycle; instr_cnt_o increments, wrapping at 2^CNT_W; -> FETCH.
- HALT/ERR:
  - absorbing; exit only by rst_i.
  - halted_o=1, all enables 0, PC never committed for the halting/faulting instruction.
  - start_i ignored.
- Latency with zero memory wait:
  - 1/7 (NOP, JXX): 4 cycles.
  - 2/3/6: 5 cycles.
  - 4 (RMMOVQ): 5 cycles.
  - 5/8/9/A/B: 6 cycles.
  - Each FETCH or MEMORY wait cycle adds 1.
- stat_o stays 1 until a fault or halt sets it; holds thereafter until reset.

Test Plan:
- Reset, start_i pulse, icode 1 valid immediately -> fetch/decode/execute/pc_en each high 1 cycle in order, pc_en_o in 4th cycle after FETCH entry, instr_cnt_o=1, back in FETCH.
- Stream icodes 6, 5, 4 with dmem_ready_i high on first MEMORY cycle -> OPQ 5 cycles with wb_en_o, MRMOVQ 6 cycles, RMMOVQ 5 cycles with no wb_en_o; instr_cnt_o=3.
- icode 9, dmem_ready_i delayed 3 cycles -> mem_en_o high 4 cycles, then WRITEBACK, PC_UPD; dmem_ready_i never asserted -> ERR after 15 wait cycles, stat_o=3, halted_o=1, pc_en_o never pulses.
- icode 0 -> HALT, stat_o=2, halted_o=1, all enables 0, start_i ignored.
- icode 0xC -> ERR, stat_o=4.
- imem_error_i and instr_valid_i in the same cycle -> ERR, stat_o=3.
- dmem_ready_i and dmem_error_i in the same cycle -> ERR, stat_o=3.
- rst_i asserted mid-MEMORY and while in HALT -> next cycle state_o=0, enables 0, stat_o=1, halted_o=0, instr_cnt_o=0.
- CNT_W=2, retire 5 NOPs -> instr_cnt_o sequence 1,2,3,0,1.
